// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared constants and FSM state type for the ping-pong read controller
package pingpong_pkg;
  localparam int DEPTH  = 35500;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = 4;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
endpackage

// File: rtl/pp_prefetch_fifo.sv
// pp_prefetch_fifo: small synchronous FIFO with occupancy count for read-credit accounting
module pp_prefetch_fifo #(
  parameter int W  = 17,
  parameter int D  = 4,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk_100m,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  logic [W-1:0] mem [D];
  logic [PW-1:0] wp, rp;
  logic do_rd;
  assign do_rd = rd & ~empty;
  assign empty = (count == '0);
  assign rdata = mem[rp];
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= (wp == PW'(D - 1)) ? '0 : wp + 1'b1;
      if (do_rd) rp <= (rp == PW'(D - 1)) ? '0 : rp + 1'b1;
      count <= count + CW'(wr) - CW'(do_rd);
    end
  end
  always_ff @(posedge clk_100m) begin
    if (wr) mem[wp] <= wdata;
  end
endmodule

// File: rtl/pingpong_ram_rd.sv
// pingpong_ram_rd: reads completed ping-pong banks in order and streams them over valid/ready
module pingpong_ram_rd #(
  parameter int DEPTH  = pingpong_pkg::DEPTH,
  parameter int AW     = pingpong_pkg::AW,
  parameter int DW     = pingpong_pkg::DW,
  parameter int RD_LAT = pingpong_pkg::RD_LAT,
  parameter int FIFO_D = pingpong_pkg::FIFO_D
) (
  input  logic          clk_100m,
  input  logic          rst_n,
  input  logic          ram_1_full,
  input  logic          ram_2_full,
  output logic          en_rd1,
  output logic          en_rd2,
  output logic [AW-1:0] addr_rd,
  input  logic [DW-1:0] dout_1,
  input  logic [DW-1:0] dout_2,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          rd_done1,
  output logic          rd_done2,
  output logic          busy,
  output logic          overrun,
  output logic [7:0]    overrun_cnt
);
  import pingpong_pkg::*;
  localparam int CW = $clog2(FIFO_D + 1);
  state_t state, state_n;
  logic [AW-1:0] issue_addr, rcv_cnt;
  logic sel, full1_q, full2_q, pend1, pend2;
  logic rise1, rise2, ov1, ov2, take1, take2;
  logic issue, last_issue, wr, pop, last_beat, empty, head_last;
  logic [RD_LAT-1:0] vld_d, bank_d;
  logic [CW-1:0] outst, count;
  logic [DW-1:0] head_data;
  logic [8:0] ov_sum;
  assign busy  = (state != IDLE);
  assign rise1 = ram_1_full & ~full1_q;
  assign rise2 = ram_2_full & ~full2_q;
  // an edge for a bank already queued or being read is an overrun and never re-queues it
  assign ov1   = rise1 & (pend1 | (busy & ~sel));
  assign ov2   = rise2 & (pend2 | (busy & sel));
  assign take1 = (state == IDLE) & pend1;
  assign take2 = (state == IDLE) & pend2 & ~pend1;
  // credit covers reads in the BRAM pipeline plus entries already buffered
  assign issue = (state == READ) & (int'(issue_addr) < DEPTH) & (int'(outst) + int'(count) < FIFO_D);
  assign last_issue = issue & (issue_addr == AW'(DEPTH - 1));
  assign wr        = vld_d[RD_LAT-1];
  assign pop       = m_tvalid & m_tready;
  assign last_beat = pop & m_tlast;
  assign en_rd1    = issue & ~sel;
  assign en_rd2    = issue & sel;
  assign addr_rd   = issue_addr;
  assign m_tvalid  = ~empty;
  assign m_tdata   = empty ? '0 : head_data;
  assign m_tlast   = ~empty & head_last;
  assign rd_done1  = (state == DRAIN) & last_beat & ~sel;
  assign rd_done2  = (state == DRAIN) & last_beat & sel;
  assign ov_sum    = 9'(overrun_cnt) + 9'(ov1) + 9'(ov2);
  always_comb begin
    state_n = (state == IDLE) ? ((pend1 | pend2) ? READ : IDLE)
            : (state == READ) ? (last_issue ? DRAIN : READ)
            : (last_beat ? IDLE : DRAIN);
  end
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      full1_q     <= 1'b0;
      full2_q     <= 1'b0;
      pend1       <= 1'b0;
      pend2       <= 1'b0;
      sel         <= 1'b0;
      issue_addr  <= '0;
      rcv_cnt     <= '0;
      vld_d       <= '0;
      bank_d      <= '0;
      outst       <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_n;
      full1_q     <= ram_1_full;
      full2_q     <= ram_2_full;
      pend1       <= (pend1 & ~take1) | (rise1 & ~ov1);
      pend2       <= (pend2 & ~take2) | (rise2 & ~ov2);
      sel         <= take1 ? 1'b0 : take2 ? 1'b1 : sel;
      issue_addr  <= (state == IDLE) ? '0 : issue_addr + AW'(issue & ~last_issue);
      rcv_cnt     <= (state == IDLE) ? '0 : rcv_cnt + AW'(wr & (rcv_cnt != AW'(DEPTH - 1)));
      vld_d       <= RD_LAT'({vld_d, issue});
      bank_d      <= RD_LAT'({bank_d, sel});
      outst       <= outst + CW'(issue) - CW'(wr);
      overrun     <= overrun | ov1 | ov2;
      overrun_cnt <= ov_sum[8] ? 8'hff : ov_sum[7:0];
    end
  end
  pp_prefetch_fifo #(.W(DW + 1), .D(FIFO_D), .CW(CW)) u_fifo (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .wr       (wr),
    .wdata    ({rcv_cnt == AW'(DEPTH - 1), bank_d[RD_LAT-1] ? dout_2 : dout_1}),
    .rd       (m_tready),
    .rdata    ({head_last, head_data}),
    .empty    (empty),
    .count    (count)
  );
endmodule

// File: tb/tb_pingpong_ram_rd.sv
// tb_pingpong_ram_rd: randomized ping-pong read bench with a bank-stream reference queue
module tb_pingpong_ram_rd;
  localparam int TD = 64, AW = 16, DW = 16, RD_LAT = 2, FIFO_D = 4;
  typedef struct {int bank; logic [DW-1:0] d; bit last;} beat_t;
  logic clk_100m = 0, rst_n = 0, ram_1_full = 0, ram_2_full = 0, m_tready = 0;
  logic en_rd1, en_rd2, m_tvalid, m_tlast, rd_done1, rd_done2, busy, overrun;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] dout_1 = '0, dout_2 = '0, s1 = '0, s2 = '0, m_tdata, hold_d;
  logic [7:0] overrun_cnt;
  logic [DW-1:0] mem1 [TD];
  logic [DW-1:0] mem2 [TD];
  logic [1:0] e_en;
  logic hold_l;
  beat_t exp_q[$];
  beat_t b;
  int done_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_beats = 0, n_en2 = 0, occ = 0, exp_addr = 0;
  int t_busy = 0, t_val = 0, rdy_pct = 100;
  bit hold_v = 0, busy_p = 0, tv_p = 0;

  pingpong_ram_rd #(.DEPTH(TD), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .ram_1_full(ram_1_full), .ram_2_full(ram_2_full),
    .en_rd1(en_rd1), .en_rd2(en_rd2), .addr_rd(addr_rd), .dout_1(dout_1), .dout_2(dout_2),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .rd_done1(rd_done1), .rd_done2(rd_done2), .busy(busy), .overrun(overrun),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // two-stage BRAM: data appears RD_LAT cycles after an enabled address
  always @(posedge clk_100m) begin
    if (en_rd1) s1 <= mem1[addr_rd[5:0]];
    if (en_rd2) s2 <= mem2[addr_rd[5:0]];
    dout_1 <= s1;
    dout_2 <= s2;
  end

  initial forever begin
    @(posedge clk_100m);
    #1 m_tready = ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk_100m) begin
    cyc++;
    if (!rst_n) begin
      hold_v = 0; occ = 0; exp_addr = 0; busy_p = 0; tv_p = 0;
    end else begin
      if (hold_v) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, hold_d);
        check("hold_last", m_tlast, hold_l);
      end
      if (busy && !busy_p) t_busy = cyc;
      if (m_tvalid && !tv_p) t_val = cyc;
      if (en_rd1 | en_rd2) begin
        e_en = (exp_q.size() == 0) ? 2'b00 : (exp_q[0].bank == 1) ? 2'b10 : 2'b01;
        check("en_sel", {en_rd1, en_rd2}, e_en);
        check("addr_rd", addr_rd, exp_addr);
        exp_addr++;
        occ++;
        if (en_rd2) n_en2++;
      end
      if (!busy) exp_addr = 0;
      if (m_tvalid & m_tready) begin
        occ--;
        n_beats++;
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("tdata", m_tdata, b.d);
          check("tlast", m_tlast, b.last);
        end
      end
      if (en_rd1 | en_rd2) check("fifo_bound", occ <= FIFO_D, 1);
      if (rd_done1 | rd_done2) begin
        done_q.push_back(rd_done2 ? 2 : 1);
        check("done_on_last", m_tvalid & m_tready & m_tlast, 1);
        check("done_onehot", rd_done1 & rd_done2, 0);
      end
      hold_v = m_tvalid & !m_tready;
      hold_d = m_tdata;
      hold_l = m_tlast;
      busy_p = busy;
      tv_p = m_tvalid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < TD; i++) begin
      mem1[i] = DW'($urandom);
      mem2[i] = DW'($urandom);
    end
  endtask

  task automatic push_bank(input int bk);
    for (int i = 0; i < TD; i++)
      exp_q.push_back(beat_t'{bk, (bk == 1) ? mem1[i] : mem2[i], i == TD - 1});
  endtask

  task automatic pulse(input int bk, input int n);
    if (bk == 1) ram_1_full = 1; else ram_2_full = 1;
    tick(n);
    if (bk == 1) ram_1_full = 0; else ram_2_full = 0;
    tick(1);
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < lim) begin
      tick(1);
      k++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("back_idle", busy, 0);
  endtask

  task automatic check_zero(input string p);
    check({p, "_tvalid"}, m_tvalid, 0);
    check({p, "_tdata"}, m_tdata, 0);
    check({p, "_tlast"}, m_tlast, 0);
    check({p, "_en_rd1"}, en_rd1, 0);
    check({p, "_en_rd2"}, en_rd2, 0);
    check({p, "_addr"}, addr_rd, 0);
    check({p, "_done1"}, rd_done1, 0);
    check({p, "_done2"}, rd_done2, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_overrun"}, overrun, 0);
    check({p, "_ovr_cnt"}, overrun_cnt, 0);
  endtask

  initial begin
    int k;
    fill();
    tick(3);
    check_zero("reset");
    rst_n = 1;
    tick(2);
    // single bank, always ready
    rdy_pct = 100;
    n_beats = 0; n_en2 = 0; done_q.delete();
    push_bank(1);
    pulse(1, 11);
    wait_done(2000);
    check("t1_beats", n_beats, TD);
    check("t1_done_n", done_q.size(), 1);
    check("t1_done0", done_q.size() > 0 ? done_q[0] : 0, 1);
    check("t1_en_rd2", n_en2, 0);
    check("t1_latency", t_val - t_busy, RD_LAT + 1);
    check("t1_overrun", overrun, 0);
    // bank 2 under random backpressure
    fill();
    rdy_pct = 50;
    n_beats = 0; done_q.delete();
    push_bank(2);
    pulse(2, 3);
    wait_done(4000);
    check("t2_beats", n_beats, TD);
    check("t2_done_n", done_q.size(), 1);
    check("t2_done0", done_q.size() > 0 ? done_q[0] : 0, 2);
    // ping-pong: bank 2 requested while bank 1 is still streaming
    fill();
    rdy_pct = 80;
    done_q.delete();
    push_bank(1);
    push_bank(2);
    pulse(1, 2);
    tick(20);
    pulse(2, 2);
    wait_done(4000);
    check("t3_done_n", done_q.size(), 2);
    check("t3_done0", done_q.size() > 0 ? done_q[0] : 0, 1);
    check("t3_done1", done_q.size() > 1 ? done_q[1] : 0, 2);
    check("t3_overrun", overrun, 0);
    // simultaneous edges: bank 1 wins
    fill();
    rdy_pct = 100;
    done_q.delete();
    push_bank(1);
    push_bank(2);
    ram_1_full = 1; ram_2_full = 1;
    tick(2);
    ram_1_full = 0; ram_2_full = 0;
    tick(1);
    wait_done(4000);
    check("t4_done_n", done_q.size(), 2);
    check("t4_done0", done_q.size() > 0 ? done_q[0] : 0, 1);
    check("t4_done1", done_q.size() > 1 ? done_q[1] : 0, 2);
    check("t4_overrun", overrun, 0);
    // overrun: repeated bank 1 edges while bank 1 is stalled in READ
    fill();
    done_q.delete();
    push_bank(1);
    pulse(1, 2);
    tick(10);
    rdy_pct = 0;
    tick(5);
    check("t5_busy", busy, 1);
    pulse(1, 1);
    check("t5_overrun", overrun, 1);
    check("t5_cnt1", overrun_cnt, 1);
    repeat (10) pulse(1, 1);
    check("t5_cnt11", overrun_cnt, 11);
    repeat (290) pulse(1, 1);
    check("t5_cnt_sat", overrun_cnt, 255);
    rdy_pct = 50;
    wait_done(4000);
    check("t5_done_n", done_q.size(), 1);
    check("t5_done0", done_q.size() > 0 ? done_q[0] : 0, 1);
    check("t5_sticky", overrun, 1);
    check("t5_cnt_end", overrun_cnt, 255);
    // asynchronous reset in the middle of a bank read
    rdy_pct = 100;
    push_bank(1);
    pulse(1, 2);
    k = 0;
    while (addr_rd < AW'(TD / 2) && k < 200) begin
      tick(1);
      k++;
    end
    check("t6_mid_read", busy, 1);
    #2 rst_n = 0;
    #1 check_zero("t6_async");
    exp_q.delete();
    tick(2);
    rst_n = 1;
    tick(2);
    fill();
    done_q.delete();
    push_bank(2);
    pulse(2, 2);
    wait_done(2000);
    check("t6_done_n", done_q.size(), 1);
    check("t6_done0", done_q.size() > 0 ? done_q[0] : 0, 2);
    check("t6_overrun", overrun, 0);
    check("t6_cnt", overrun_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
